smpl_capture_ctrl: RTL

Circular-buffer write controller that sits directly downstream of the clock/reset/sample generator. It consumes the one-cycle `wrt_smpl` pulse, which means "4 samples packed, ready for RAM". It produces the RAM write strobe and address, and runs the pre-trigger fill, arm, post-trigger count and done sequence. It also reports the buffer address where the trigger occurred so readout can unroll the capture.

---
 rtl/smpl_capture_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/smpl_capture_ctrl.sv
// smpl_capture_ctrl: circular-buffer RAM write controller for the sample capture path.
// It turns one-cycle wrt_smpl pulses into registered RAM write strobes and addresses,
// and runs the capture sequence: pre-trigger fill, armed, post-trigger count, done.
// It also records the buffer address of the first post-trigger word, so that readout
// can unroll the circular buffer into time order.

module smpl_capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt_smpl,
    input  logic              run,
    input  logic              trig,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } state_t;

    // The buffer depth needs one more bit than an address, so that a full
    // 2^ADDR_W-word fill (trig_pos = 0) can be counted.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_next;
    logic [ADDR_W-1:0] tp_l;
    logic [ADDR_W-1:0] tp_next;
    logic [ADDR_W-1:0] trig_addr_next;
    logic [ADDR_W-1:0] waddr_next;
    logic              we_next;
    logic              do_write;

    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   tp_ext;
    logic [ADDR_W:0]   fill_target;

    // The pre-trigger region holds DEPTH - tp_l words, and the post-trigger region holds tp_l words.
    assign cnt_inc     = cnt + (ADDR_W+1)'(1);
    assign tp_ext      = {1'b0, tp_l};
    assign fill_target = DEPTH - tp_ext;

    // The status flags are plain decodes of the state register, so they change
    // on the same edge as the registered write strobe.
    assign armed        = (state == ARMED);
    assign triggered    = (state == POST);
    assign capture_done = (state == DONE);

    // Next-state and datapath decisions. A write performed in this cycle is
    // registered onto we/waddr. Then ptr advances and wraps at DEPTH.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        cnt_next       = cnt;
        tp_next        = tp_l;
        trig_addr_next = trig_addr;
        waddr_next     = waddr;
        we_next        = 1'b0;
        do_write       = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FILL;
                    ptr_next   = '0;
                    cnt_next   = '0;
                    tp_next    = trig_pos;
                end
            end

            FILL: begin
                if (wrt_smpl) begin
                    do_write = 1'b1;
                    cnt_next = cnt_inc;
                    if (cnt_inc == fill_target) begin
                        state_next = ARMED;
                    end
                end
            end

            ARMED: begin
                if (trig) begin
                    trig_addr_next = ptr;
                    cnt_next       = '0;
                    if (tp_l == '0) begin
                        // No post-trigger words are wanted, so a coincident sample is discarded.
                        state_next = DONE;
                    end else if (wrt_smpl) begin
                        // A coincident sample is the first post-trigger word.
                        do_write = 1'b1;
                        cnt_next = (ADDR_W+1)'(1);
                        if (tp_ext == (ADDR_W+1)'(1)) begin
                            state_next = DONE;
                        end else begin
                            state_next = POST;
                        end
                    end else begin
                        state_next = POST;
                    end
                end else if (wrt_smpl) begin
                    do_write = 1'b1;
                end
            end

            POST: begin
                if (wrt_smpl) begin
                    do_write = 1'b1;
                    cnt_next = cnt_inc;
                    if (cnt_inc == tp_ext) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                if (run) begin
                    state_next = FILL;
                    ptr_next   = '0;
                    cnt_next   = '0;
                    tp_next    = trig_pos;
                end else if (clr_done) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (do_write) begin
            we_next    = 1'b1;
            waddr_next = ptr;
            ptr_next   = ptr + ADDR_W'(1);
        end
    end

    // State register. The asynchronous reset returns the controller to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. Reset clears every output at once, including a write in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            tp_l      <= '0;
            trig_addr <= '0;
            waddr     <= '0;
            we        <= 1'b0;
        end else begin
            ptr       <= ptr_next;
            cnt       <= cnt_next;
            tp_l      <= tp_next;
            trig_addr <= trig_addr_next;
            waddr     <= waddr_next;
            we        <= we_next;
        end
    end

endmodule
